inst_sram_slave: RTL and testbench

- Responder end of the instruction SRAM port driven by the fetch stage (en/we[3:0]/addr/wdata in, rdata out).
- Fixed one-cycle read latency: rdata is valid the cycle after en is sampled.
- Backed by an internal word array mapped at BASE. A streaming image loader fills the array after reset, before the core is released.
- Sits in the SoC wrapper between the CPU fetch port and the boot-image source.

---
 rtl/inst_sram_slave_pkg.sv | 14 +
 rtl/inst_sram_array.sv | 75 +++++++
 rtl/inst_sram_slave.sv | 130 +++++++++++++
 tb/tb_inst_sram_slave.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_sram_slave_pkg.sv
// Shared constants for the instruction SRAM responder: default address map,
// out-of-range fill word and loader/fetch FSM state encodings.
package inst_sram_slave_pkg;

    localparam logic [31:0] BASE_DEFAULT = 32'h1c000000;
    localparam logic [31:0] FILL_DEFAULT = 32'h00000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/inst_sram_array.sv
// Synchronous single-port word array with byte write enables and a registered
// read port. Define INST_SRAM_PARITY_EN to store and check an even-parity bit per word.
module inst_sram_array #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
`ifdef INST_SRAM_PARITY_EN
    , output logic        perr
`endif
);

    localparam int DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH];
    logic [31:0] merged;
    logic        wr;
    logic        rd;

    assign wr = en && (we != 4'b0000);
    assign rd = en && (we == 4'b0000);

    // Partial writes merge into the current word so parity covers the final value.
    always_comb begin
        merged = mem[idx];
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

`ifdef INST_SRAM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[idx]     <= merged;
            par_mem[idx] <= ^merged;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q    <= 32'h0;
            perr <= 1'b0;
        end else begin
            if (rd) begin
                q <= mem[idx];
            end
            perr <= rd && ((^mem[idx]) != par_mem[idx]);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= 32'h0;
        end else if (rd) begin
            q <= mem[idx];
        end
    end
`endif

endmodule

// File: rtl/inst_sram_slave.sv
// Instruction SRAM responder: boot-image loader, then a one-cycle-latency fetch port.
// Define INST_SRAM_PARITY_EN to add per-word parity and the parity_err output.
module inst_sram_slave
    import inst_sram_slave_pkg::*;
#(
    parameter logic [31:0] BASE = BASE_DEFAULT,
    parameter int          AW   = 12,
    parameter logic [31:0] FILL = FILL_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        mem_ready,
    output logic        addr_fault
`ifdef INST_SRAM_PARITY_EN
    , output logic      parity_err
`endif
);

    localparam logic [31:0] DEPTH = 32'(1) << AW;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] ptr;
    logic          ld_fire;

    logic [31:0]   off;
    logic [31:0]   word_off;
    logic          in_range;
    logic          aligned;
    logic          addr_ok;
    logic          req;
    logic          req_rd;

    logic          arr_en;
    logic [3:0]    arr_we;
    logic [AW-1:0] arr_idx;
    logic [31:0]   arr_wdata;
    logic [31:0]   arr_q;
    logic          fill_p1;

    assign ld_fire = (state == LOAD) && ld_valid;

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        mem_ready = 1'b0;
        case (state)
            IDLE: state_nxt = LOAD;
            LOAD: begin
                ld_ready = 1'b1;
                // A full array ends the image even without ld_last; extra words are dropped.
                if (ld_fire && (ld_last || ptr == '1)) begin
                    state_nxt = RUN;
                end
            end
            RUN:  mem_ready = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // Unsigned 32-bit math: addresses below BASE wrap to huge offsets and fail the range test.
    assign off      = inst_sram_addr - BASE;
    assign word_off = off >> 2;
    assign in_range = (inst_sram_addr >= BASE) && (word_off < DEPTH);
    assign aligned  = (inst_sram_addr[1:0] == 2'b00);
    assign addr_ok  = in_range && aligned;
    assign req      = (state == RUN) && inst_sram_en;
    assign req_rd   = req && (inst_sram_we == 4'b0000);

    always_comb begin
        arr_en    = 1'b0;
        arr_we    = inst_sram_we;
        arr_idx   = word_off[AW-1:0];
        arr_wdata = inst_sram_wdata;
        if (state == LOAD) begin
            arr_en    = ld_fire;
            arr_we    = 4'b1111;
            arr_idx   = ptr;
            arr_wdata = ld_data;
        end else begin
            arr_en    = req && addr_ok;
        end
    end

    inst_sram_array #(.AW(AW)) u_array (
        .clk    (clk),
        .resetn (resetn),
        .en     (arr_en),
        .we     (arr_we),
        .idx    (arr_idx),
        .wdata  (arr_wdata),
        .q      (arr_q)
`ifdef INST_SRAM_PARITY_EN
        , .perr (parity_err)
`endif
    );

    // Stage p1: fault and fill-select registered alongside the array read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            ptr        <= '0;
            fill_p1    <= 1'b0;
            addr_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ld_fire) begin
                ptr <= ptr + 1'b1;
            end
            if (req) begin
                addr_fault <= !addr_ok;
            end
            if (req_rd) begin
                fill_p1 <= !addr_ok;
            end
        end
    end

    assign inst_sram_rdata = fill_p1 ? FILL : arr_q;

endmodule

// File: tb/tb_inst_sram_slave.sv
// Randomised self-checking bench for inst_sram_slave against a word-array reference model.
// Define INST_SRAM_PARITY_EN to also exercise the parity_err output.
module tb_inst_sram_slave;

    localparam logic [31:0] BASE  = 32'h1c000000;
    localparam int          AW    = 12;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] FILL  = 32'hDEADBEEF;

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        mem_ready;
    logic        addr_fault;
`ifdef INST_SRAM_PARITY_EN
    logic        parity_err;
`endif

    inst_sram_slave #(.BASE(BASE), .AW(AW), .FILL(FILL)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_data         (ld_data),
        .ld_last         (ld_last),
        .mem_ready       (mem_ready),
        .addr_fault      (addr_fault)
`ifdef INST_SRAM_PARITY_EN
        , .parity_err    (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain word array plus a flag for words whose value is defined.
    logic [31:0] ref_mem [DEPTH];
    bit          known   [DEPTH];
    logic [31:0] exp_rdata;
    bit          exp_known;
    bit          exp_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_sram_en    = 1'b0;
        inst_sram_we    = 4'b0000;
        inst_sram_addr  = 32'h0;
        inst_sram_wdata = 32'h0;
        ld_valid        = 1'b0;
        ld_data         = 32'h0;
        ld_last         = 1'b0;
    endtask

    // Asynchronous reset mid-cycle, check outputs immediately, then release into LOAD.
    task automatic reset_and_release(input string tag);
        #2;
        resetn = 1'b0;
        idle_inputs();
        #1;
        check({tag, "_rst_rdata"},  inst_sram_rdata,  32'h0);
        check({tag, "_rst_ldrdy"},  32'(ld_ready),    32'h0);
        check({tag, "_rst_memrdy"}, 32'(mem_ready),   32'h0);
        check({tag, "_rst_fault"},  32'(addr_fault),  32'h0);
        @(negedge clk);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        exp_rdata = 32'h0;
        exp_known = 1'b1;
        exp_fault = 1'b0;
        tick();
        check({tag, "_load_ldrdy"},  32'(ld_ready),  32'h1);
        check({tag, "_load_memrdy"}, 32'(mem_ready), 32'h0);
    endtask

    // Streams n words; gap cycles carry junk data and fetch requests that must be ignored.
    task automatic load_words(input int n, input logic [31:0] first, input logic [31:0] step,
                              input bit use_last);
        logic [31:0] d;
        d = first;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                ld_valid       = 1'b0;
                ld_data        = $urandom;
                inst_sram_en   = 1'b1;
                inst_sram_we   = 4'b0000;
                inst_sram_addr = ($urandom % 2 == 0) ? BASE : BASE - 32'h4;
                tick();
            end
            inst_sram_en = 1'b0;
            if (use_last && i == n - 1) begin
                check("memrdy_before_last", 32'(mem_ready), 32'h0);
            end
            ld_valid = 1'b1;
            ld_data  = d;
            ld_last  = use_last && (i == n - 1);
            tick();
            ref_mem[i] = d;
            known[i]   = 1'b1;
            d          = d + step;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (use_last) begin
            check("memrdy_after_last", 32'(mem_ready), 32'h1);
            check("ldrdy_after_last",  32'(ld_ready),  32'h0);
            check("rdata_held_in_load", inst_sram_rdata, exp_rdata);
            check("fault_held_in_load", 32'(addr_fault), 32'(exp_fault));
        end
    endtask

    task automatic fetch(input bit en, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        logic [31:0] off;
        bit          ok;
        int          idx;
        inst_sram_en    = en;
        inst_sram_we    = we;
        inst_sram_addr  = addr;
        inst_sram_wdata = wdata;
        off = addr - BASE;
        ok  = (addr >= BASE) && ((off >> 2) < 32'(DEPTH)) && (addr[1:0] == 2'b00);
        idx = int'(off >> 2);
        if (en) begin
            exp_fault = !ok;
            if (we == 4'b0000) begin
                if (ok) begin
                    exp_rdata = ref_mem[idx];
                    exp_known = known[idx];
                end else begin
                    exp_rdata = FILL;
                    exp_known = 1'b1;
                end
            end else if (ok) begin
                for (int b = 0; b < 4; b++) begin
                    if (we[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
                if (we == 4'b1111) known[idx] = 1'b1;
            end
        end
        tick();
        inst_sram_en = 1'b0;
        if (exp_known) check("rdata", inst_sram_rdata, exp_rdata);
        check("addr_fault", 32'(addr_fault), 32'(exp_fault));
`ifdef INST_SRAM_PARITY_EN
        check("parity_err_clean", 32'(parity_err), 32'h0);
`endif
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom % 10)
            0:       return BASE + 32'(($urandom % 16) * 4) + 32'($urandom_range(1, 3));
            1:       return BASE - 32'(4 * $urandom_range(1, 4));
            2:       return BASE + 32'(DEPTH * 4) + 32'(4 * ($urandom % 4));
            default: return BASE + 32'(($urandom % 16) * 4);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        resetn = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset_and_release("por");

        load_words(4, 32'h11111111, 32'h11111111, 1'b1);
        fetch(1'b1, 4'b0000, BASE + 32'h8, 32'h0);
        check("plan_read8", inst_sram_rdata, 32'h33333333);

        fetch(1'b1, 4'b0000, BASE + 32'hc, 32'h0);
        for (int i = 0; i < 3; i++) fetch(1'b0, 4'(($urandom % 2) * 4'hf), rand_addr(), $urandom);
        check("plan_hold", inst_sram_rdata, 32'h44444444);

        fetch(1'b1, 4'b0011, BASE, 32'hAAAABBBB);
        fetch(1'b1, 4'b0000, BASE, 32'h0);
        check("plan_partial", inst_sram_rdata, 32'h1111BBBB);

        fetch(1'b1, 4'b0000, 32'h1bfffffc, 32'h0);
        fetch(1'b1, 4'b0000, 32'h1c000002, 32'h0);
        fetch(1'b1, 4'b0000, 32'h1c000004, 32'h0);
        check("plan_recover", inst_sram_rdata, 32'h22222222);

        // Edge of the array, just past it, and writes that must be dropped.
        fetch(1'b1, 4'b1111, BASE + 32'(4 * (DEPTH - 1)), 32'hCAFEF00D);
        fetch(1'b1, 4'b0000, BASE + 32'(4 * (DEPTH - 1)), 32'h0);
        fetch(1'b1, 4'b0000, BASE + 32'(4 * DEPTH), 32'h0);
        fetch(1'b1, 4'b1111, BASE + 32'(4 * DEPTH), 32'h0BADBAD0);
        fetch(1'b1, 4'b1111, BASE + 32'h2, 32'h0BADBAD1);
        fetch(1'b1, 4'b1111, 32'h00000000, 32'h0BADBAD2);
        fetch(1'b1, 4'b0000, BASE, 32'h0);
        fetch(1'b1, 4'b0000, BASE + 32'h4, 32'h0);

`ifdef INST_SRAM_PARITY_EN
        dut.u_array.par_mem[1] = ~dut.u_array.par_mem[1];
        inst_sram_en   = 1'b1;
        inst_sram_we   = 4'b0000;
        inst_sram_addr = BASE + 32'h4;
        tick();
        inst_sram_en = 1'b0;
        check("parity_err_set", 32'(parity_err), 32'h1);
        check("parity_rdata", inst_sram_rdata, ref_mem[1]);
        tick();
        check("parity_err_once", 32'(parity_err), 32'h0);
        dut.u_array.par_mem[1] = ~dut.u_array.par_mem[1];
`endif

        for (int i = 4; i < 16; i++) fetch(1'b1, 4'b1111, BASE + 32'(4 * i), $urandom);
        for (int i = 0; i < 400; i++) begin
            fetch(($urandom % 4) != 0, ($urandom % 2 == 0) ? 4'b0000 : 4'($urandom),
                  rand_addr(), $urandom);
        end

        // Reset while RUN output is non-zero, then reset again partway through a load.
        fetch(1'b1, 4'b0000, BASE + 32'h4, 32'h0);
        reset_and_release("run");
        load_words(2, 32'h5A5A0001, 32'h1, 1'b0);
        reset_and_release("midload");
        load_words(4, 32'h0F0F0000, 32'h00010001, 1'b1);
        fetch(1'b1, 4'b0000, BASE, 32'h0);
        check("reload_word0", inst_sram_rdata, 32'h0F0F0000);
        fetch(1'b1, 4'b0000, BASE + 32'hc, 32'h0);

        // Image longer than the array: loading stops at the wrap.
        reset_and_release("wrap");
        cnt = 0;
        while (ld_ready && cnt < DEPTH + 8) begin
            ld_valid = 1'b1;
            ld_data  = 32'(cnt) ^ 32'hA5A50000;
            ld_last  = 1'b0;
            tick();
            ref_mem[cnt % DEPTH] = 32'(cnt) ^ 32'hA5A50000;
            known[cnt % DEPTH]   = 1'b1;
            cnt++;
        end
        ld_valid = 1'b0;
        check("wrap_count", 32'(cnt), 32'(DEPTH));
        check("wrap_memrdy", 32'(mem_ready), 32'h1);
        fetch(1'b1, 4'b0000, BASE, 32'h0);
        fetch(1'b1, 4'b0000, BASE + 32'(4 * (DEPTH - 1)), 32'h0);
        for (int i = 0; i < 40; i++) begin
            fetch(1'b1, 4'b0000, BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
